// File: rtl/mem_access_ctrl.sv
// Arbitrates a fetch port and a load/store port onto one word-addressed memory.
// Sub-word stores off lane 0 use a read-modify-write; misaligned or illegal accesses error out.
module mem_access_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W+1:0] if_addr,
  output logic              if_valid,
  output logic              if_err,
  output logic [31:0]       if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [2:0]        ls_funct3,
  input  logic [ADDR_W+1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_done,
  output logic              ls_err,
  output logic [31:0]       ls_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_word_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [1:0]        mem_save_method,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [1:0] SM_SW = 2'd0;
  localparam logic [1:0] SM_SH = 2'd1;
  localparam logic [1:0] SM_SB = 2'd2;

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, STORE, RMW_RD, RMW_WR, RESP
  } state_t;

  state_t              r_state, w_next;
  logic                r_last_fetch;
  logic [ADDR_W+1:0]   r_addr;
  logic [2:0]          r_funct3;
  logic [31:0]         r_wdata;

  logic                w_pick_ls, w_pick_if;
  logic                w_ls_bad, w_ls_rmw, w_if_bad;
  logic [4:0]          w_shift;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic [31:0]         w_load_ext, w_merged;

  // Alternate on ties; with only one requester it wins outright
  assign w_pick_ls = ls_req && (!if_req || r_last_fetch);
  assign w_pick_if = if_req && !w_pick_ls;
  assign w_if_bad  = (if_addr[1:0] != 2'b00);

  // Classify the incoming load/store request
  always_comb begin
    w_ls_bad = 1'b0;
    w_ls_rmw = 1'b0;
    if (ls_we) begin
      if (ls_funct3 > 3'b010) w_ls_bad = 1'b1;
    end else begin
      if (ls_funct3 == 3'b011 || ls_funct3 > 3'b101) w_ls_bad = 1'b1;
    end
    if (ls_funct3[1:0] == 2'b01 && ls_addr[0]) w_ls_bad = 1'b1;
    if (ls_funct3[1:0] == 2'b10 && ls_addr[1:0] != 2'b00) w_ls_bad = 1'b1;
    if (ls_we && ls_funct3 == 3'b000 && ls_addr[1:0] != 2'b00) w_ls_rmw = 1'b1;
    if (ls_we && ls_funct3 == 3'b001 && ls_addr[1]) w_ls_rmw = 1'b1;
  end

  // Load lane extraction and store-lane merge for RMW
  always_comb begin
    w_shift = {r_addr[1:0], 3'b000};
    w_byte  = 8'(mem_rdata >> w_shift);
    w_half  = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_funct3)
      3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_ext = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_ext = {24'd0, w_byte};
      3'b101:  w_load_ext = {16'd0, w_half};
      default: w_load_ext = mem_rdata;
    endcase
    w_merged = mem_rdata;
    if (r_funct3[0]) begin
      w_merged[31:16] = r_wdata[15:0];
    end else begin
      case (r_addr[1:0])
        2'd1:    w_merged[15:8]  = r_wdata[7:0];
        2'd2:    w_merged[23:16] = r_wdata[7:0];
        2'd3:    w_merged[31:24] = r_wdata[7:0];
        default: w_merged[7:0]   = r_wdata[7:0];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_pick_ls) begin
          if (w_ls_bad)      w_next = RESP;
          else if (!ls_we)   w_next = LOAD;
          else if (w_ls_rmw) w_next = RMW_RD;
          else               w_next = STORE;
        end else if (w_pick_if) begin
          w_next = w_if_bad ? RESP : FETCH;
        end
      end
      FETCH, LOAD, STORE, RMW_WR: w_next = RESP;
      RMW_RD:                     w_next = RMW_WR;
      default:                    w_next = IDLE;
    endcase
  end

  // Memory-side strobes decoded from the current state and latched request
  always_comb begin
    busy            = (r_state != IDLE);
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_word_addr   = '0;
    mem_save_method = SM_SW;
    mem_wdata       = 32'd0;
    case (r_state)
      FETCH, LOAD, RMW_RD: begin
        mem_read      = 1'b1;
        mem_word_addr = r_addr[ADDR_W+1:2];
      end
      STORE: begin
        mem_write     = 1'b1;
        mem_word_addr = r_addr[ADDR_W+1:2];
        case (r_funct3)
          3'b000: begin
            mem_save_method = SM_SB;
            mem_wdata       = {24'd0, r_wdata[7:0]};
          end
          3'b001: begin
            mem_save_method = SM_SH;
            mem_wdata       = {16'd0, r_wdata[15:0]};
          end
          default: mem_wdata = r_wdata;
        endcase
      end
      RMW_WR: begin
        mem_write     = 1'b1;
        mem_word_addr = r_addr[ADDR_W+1:2];
        mem_wdata     = r_wdata;
      end
      default: ;
    endcase
  end

  // Request latches and registered responses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_fetch <= 1'b1;
      r_addr       <= '0;
      r_funct3     <= 3'd0;
      r_wdata      <= 32'd0;
      if_valid     <= 1'b0;
      if_err       <= 1'b0;
      if_rdata     <= 32'd0;
      ls_done      <= 1'b0;
      ls_err       <= 1'b0;
      ls_rdata     <= 32'd0;
    end else begin
      if_valid <= 1'b0;
      ls_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pick_ls) begin
            r_last_fetch <= 1'b0;
            r_addr       <= ls_addr;
            r_funct3     <= ls_funct3;
            r_wdata      <= ls_wdata;
            if (w_ls_bad) begin
              ls_done  <= 1'b1;
              ls_err   <= 1'b1;
              ls_rdata <= 32'd0;
            end
          end else if (w_pick_if) begin
            r_last_fetch <= 1'b1;
            r_addr       <= if_addr;
            r_funct3     <= 3'b010;
            if (w_if_bad) begin
              if_valid <= 1'b1;
              if_err   <= 1'b1;
              if_rdata <= 32'd0;
            end
          end
        end
        FETCH: begin
          if_valid <= 1'b1;
          if_err   <= 1'b0;
          if_rdata <= mem_rdata;
        end
        LOAD: begin
          ls_done  <= 1'b1;
          ls_err   <= 1'b0;
          ls_rdata <= w_load_ext;
        end
        RMW_RD: r_wdata <= w_merged;
        STORE, RMW_WR: begin
          ls_done  <= 1'b1;
          ls_err   <= 1'b0;
          ls_rdata <= 32'd0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural word memory.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, ls_req, ls_we;
  logic [9:0]  if_addr, ls_addr;
  logic [2:0]  ls_funct3;
  logic [31:0] ls_wdata;
  logic        if_valid, if_err, ls_done, ls_err, busy;
  logic [31:0] if_rdata, ls_rdata;
  logic [7:0]  mem_word_addr;
  logic        mem_read, mem_write;
  logic [1:0]  mem_save_method;
  logic [31:0] mem_wdata, mem_rdata;

  logic [31:0] mem [256];
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  logic [1:0]  last_sm = 2'd3;
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_err(if_err), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_funct3(ls_funct3), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_done(ls_done), .ls_err(ls_err), .ls_rdata(ls_rdata), .busy(busy),
    .mem_word_addr(mem_word_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_save_method(mem_save_method), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_word_addr];

  // Memory contents and write port: 0=SW, 1=SH (low half), 2=SB (low byte)
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    mem[1]  = 32'h0010_0093;
    mem[5]  = 32'hB2E0_0293;
    mem[79] = 32'h0000_0001;
    forever begin
      @(posedge clk);
      if (mem_read) rd_cnt++;
      if (mem_write) begin
        wr_cnt++;
        last_sm = mem_save_method;
        case (mem_save_method)
          2'd1:    mem[mem_word_addr][15:0] <= mem_wdata[15:0];
          2'd2:    mem[mem_word_addr][7:0]  <= mem_wdata[7:0];
          default: mem[mem_word_addr]       <= mem_wdata;
        endcase
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Issue one load/store; returns latency in cycles and mem_read in the first cycle
  task automatic ls_op(input logic we, input logic [2:0] f3, input logic [9:0] a,
                       input logic [31:0] wd, output int n, output logic r1);
    @(negedge clk);
    ls_req = 1'b1; ls_we = we; ls_funct3 = f3; ls_addr = a; ls_wdata = wd;
    n = 0; r1 = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) r1 = mem_read;
    end while (!ls_done && n < 12);
    ls_req = 1'b0;
  endtask

  task automatic wait_resp(input bit fetch, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(fetch ? if_valid : ls_done) && n < 12);
  endtask

  int   lat, w0, r0;
  logic r1;

  initial begin
    rst = 1'b1; if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
    if_addr = '0; ls_addr = '0; ls_funct3 = '0; ls_wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_outs", {26'd0, if_valid, if_err, ls_done, ls_err, mem_read, mem_write}, 32'd0);
    check("rst_sm_addr", {22'd0, mem_save_method, mem_word_addr}, 32'd0);
    check("rst_rdata", ls_rdata | if_rdata | mem_wdata, 32'd0);

    // Word load, then pulse shape
    ls_op(1'b0, 3'b010, 10'h13C, 32'd0, lat, r1);
    check("lw_lat", 32'(lat), 32'd2);
    check("lw_rd1", 32'(r1), 32'd1);
    check("lw_data", ls_rdata, 32'h0000_0001);
    @(negedge clk);
    check("lw_pulse", 32'(ls_done), 32'd0);
    check("lw_hold", ls_rdata, 32'h0000_0001);

    // Sub-word extraction on word 5
    ls_op(1'b0, 3'b000, 10'h016, 32'd0, lat, r1);
    check("lb", ls_rdata, 32'hFFFF_FFE0);
    ls_op(1'b0, 3'b100, 10'h016, 32'd0, lat, r1);
    check("lbu", ls_rdata, 32'h0000_00E0);
    ls_op(1'b0, 3'b001, 10'h016, 32'd0, lat, r1);
    check("lh", ls_rdata, 32'hFFFF_B2E0);
    ls_op(1'b0, 3'b101, 10'h016, 32'd0, lat, r1);
    check("lhu", ls_rdata, 32'h0000_B2E0);
    ls_op(1'b0, 3'b000, 10'h017, 32'd0, lat, r1);
    check("lb_b3", ls_rdata, 32'hFFFF_FFB2);
    ls_op(1'b0, 3'b100, 10'h014, 32'd0, lat, r1);
    check("lbu_b0", ls_rdata, 32'h0000_0093);

    // Error paths: misaligned LW, illegal load funct3, misaligned SH
    r0 = rd_cnt;
    ls_op(1'b0, 3'b010, 10'h102, 32'd0, lat, r1);
    check("lw_mis_lat", 32'(lat), 32'd1);
    check("lw_mis_err", {31'd0, ls_err}, 32'd1);
    check("lw_mis_data", ls_rdata, 32'd0);
    check("lw_mis_noread", 32'(rd_cnt - r0), 32'd0);
    ls_op(1'b0, 3'b011, 10'h010, 32'd0, lat, r1);
    check("ld_f3_err", {31'd0, ls_err}, 32'd1);
    w0 = wr_cnt;
    ls_op(1'b1, 3'b001, 10'h015, 32'h1234, lat, r1);
    check("sh_mis_err", {31'd0, ls_err}, 32'd1);
    check("sh_mis_nowr", 32'(wr_cnt - w0), 32'd0);

    // Reset during RMW_RD abandons the store
    w0 = wr_cnt;
    @(negedge clk);
    ls_req = 1'b1; ls_we = 1'b1; ls_funct3 = 3'b000; ls_addr = 10'h015; ls_wdata = 32'hAB;
    @(negedge clk);
    check("rmw_rd_read", {31'd0, mem_read}, 32'd1);
    rst = 1'b1; ls_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_outs", {26'd0, if_valid, if_err, ls_done, ls_err, mem_read, mem_write}, 32'd0);
    @(negedge clk);
    check("rstmid_nowr", 32'(wr_cnt - w0), 32'd0);
    check("rstmid_word5", mem[5], 32'hB2E0_0293);

    // RMW byte store, aligned stores, RMW half store
    w0 = wr_cnt;
    ls_op(1'b1, 3'b000, 10'h015, 32'h0000_00AB, lat, r1);
    check("sb_rmw_lat", 32'(lat), 32'd3);
    check("sb_rmw_wr", 32'(wr_cnt - w0), 32'd1);
    check("sb_rmw_sm", 32'(last_sm), 32'd0);
    @(negedge clk);
    check("sb_rmw_word", mem[5], 32'hB2E0_AB93);
    w0 = wr_cnt;
    ls_op(1'b1, 3'b010, 10'h020, 32'h1234_5678, lat, r1);
    check("sw_lat", 32'(lat), 32'd2);
    ls_op(1'b1, 3'b000, 10'h024, 32'hFFFF_FFCD, lat, r1);
    check("sb0_sm", 32'(last_sm), 32'd2);
    ls_op(1'b1, 3'b001, 10'h02A, 32'h0000_BEEF, lat, r1);
    check("sh2_lat", 32'(lat), 32'd3);
    @(negedge clk);
    check("stores_wr", 32'(wr_cnt - w0), 32'd3);
    check("sw_word", mem[8], 32'h1234_5678);
    check("sb0_word", mem[9], 32'h0000_00CD);
    check("sh2_word", mem[10], 32'hBEEF_0000);

    // Misaligned fetch
    @(negedge clk);
    if_req = 1'b1; if_addr = 10'h006;
    wait_resp(1'b1, lat);
    if_req = 1'b0;
    check("if_mis_lat", 32'(lat), 32'd1);
    check("if_mis_err", {31'd0, if_err}, 32'd1);

    // Tie: data first, then a second tie goes to fetch
    @(negedge clk);
    if_req = 1'b1; if_addr = 10'h004;
    ls_req = 1'b1; ls_we = 1'b0; ls_funct3 = 3'b010; ls_addr = 10'h13C;
    wait_resp(1'b0, lat);
    check("tie_ls_lat", 32'(lat), 32'd2);
    check("tie_ls_data", ls_rdata, 32'h0000_0001);
    check("tie_no_if", {31'd0, if_valid}, 32'd0);
    ls_addr = 10'h014;
    wait_resp(1'b1, lat);
    if_req = 1'b0;
    check("tie2_if_lat", 32'(lat), 32'd3);
    check("tie2_if_data", if_rdata, 32'h0010_0093);
    check("tie2_if_err", {31'd0, if_err}, 32'd0);
    wait_resp(1'b0, lat);
    ls_req = 1'b0;
    check("tie2_ls_lat", 32'(lat), 32'd3);
    check("tie2_ls_data", ls_rdata, 32'hB2E0_AB93);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, word-address width of the shared instruction/data memory.
REQ-002 SHALL have port clk, input, 1, single clock; every register updates on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port if_req, input, 1, fetch request, held stable until if_valid.
REQ-005 SHALL have port if_addr, input, ADDR_W+2, fetch byte address.
REQ-006 SHALL have port if_valid / if_err, output, 1 each, fetch response pulse / fetch misaligned.
REQ-007 SHALL have port if_rdata, output, 32, fetched instruction.
REQ-008 SHALL have port ls_req, input, 1, load/store request, held stable until ls_done.
REQ-009 SHALL have ports ls_we (1), ls_funct3 (3), ls_addr (ADDR_W+2), ls_wdata (32), inputs: store flag, RISC-V funct3, byte address, store data.
REQ-010 SHALL have ports ls_done / ls_err, output, 1 each, response pulse / misaligned or illegal funct3.
REQ-011 SHALL have port ls_rdata, output, 32, extended load result.
REQ-012 SHALL have port busy, output, 1, high whenever state is not IDLE (pipeline stall).
REQ-013 SHALL have memory-side outputs mem_word_addr (ADDR_W), mem_read (1), mem_write (1), mem_save_method (2), mem_wdata (32), and input mem_rdata (32, combinational read).

Function
REQ-014 SHALL implement states IDLE, FETCH, LOAD, STORE, RMW_RD, RMW_WR, RESP.
REQ-015 SHALL sample requests only in IDLE; requests present in RESP are ignored.
REQ-016 SHALL, when both requests are pending in IDLE, grant the source not granted last (grant flag reset to "fetch last", so data wins first).
REQ-017 SHALL latch address, funct3, we, wdata on grant; later input changes have no effect.
REQ-018 Fetch: IDLE(T) -> FETCH(T+1, mem_read=1, word=if_addr[ADDR_W+1:2]) -> RESP(T+2, if_valid=1, if_rdata=word).
REQ-019 Load: IDLE(T) -> LOAD(T+1, mem_read=1) -> RESP(T+2, ls_done=1).
REQ-020 Load extraction, little-endian, byte b at bits [8b+7:8b]: LB/LH sign-extend, LBU/LHU zero-extend, LW whole word.
REQ-021 SW, SB at offset 0, SH at offset 0: IDLE -> STORE (one-cycle mem_write with `SW/`SB/`SH of defines.v, data in low lanes) -> RESP; done at T+2.
REQ-022 SB at offset 1-3, SH at offset 2: IDLE -> RMW_RD (mem_read, merge new lane into captured word) -> RMW_WR (mem_write, `SW, merged word) -> RESP; done at T+3.
REQ-023 Misaligned (LH/LHU/SH addr[0]=1; LW/SW addr[1:0]!=0; fetch addr[1:0]!=0) or funct3 not in {000,001,010,100,101} load / {000,001,010} store: IDLE -> RESP directly, err=1, rdata=0, no memory access.
REQ-024 mem_write SHALL be high exactly one cycle per store; never in LOAD, FETCH, RMW_RD.
REQ-025 Outside access states mem_read=0, mem_write=0, mem_word_addr=0, mem_wdata=0, mem_save_method=`SW.
REQ-026 if_valid/ls_done SHALL be single-cycle pulses in RESP; if_rdata/ls_rdata/err hold until next response.
REQ-027 Address wrap: only bits [ADDR_W+1:2] select the word; upper bits absent by width.

Reset
REQ-028 rst=1 at an edge SHALL force IDLE, grant flag "fetch last", all outputs 0 (mem_save_method=`SW) from the next cycle.
REQ-029 rst during any state SHALL abandon the transaction with no response; rst in RMW_RD SHALL suppress the pending write.

Verification
REQ-030 Word 79=0x00000001; LW ls_addr=0x13C at T -> mem_read at T+1, ls_done, ls_rdata=0x00000001 at T+2.
REQ-031 Word 5=0xB2E00293; LB addr 0x016 -> 0xFFFFFFE0; LBU -> 0x000000E0; LH addr 0x016 -> 0xFFFFB2E0.
REQ-032 Word 5=0xB2E00293; SB addr 0x015, wdata 0x000000AB -> RMW, one mem_write `SW, word 5=0xB2E0AB93, ls_done at T+3.
REQ-033 if_req addr 0x004 and ls_req LW 0x13C same cycle -> data served first, then fetch if_rdata=0x00100093; next tie granted to fetch.
REQ-034 LW addr 0x102 -> ls_err=1, ls_rdata=0, ls_done at T+1, mem_read never asserted.
REQ-035 rst asserted in RMW_RD of SB 0x015 -> no mem_write, word 5 unchanged, all outputs 0 next cycle, busy=0.
